// File: rtl/alu_req_sched_if.sv
// ---------------------------------------------------------------------------
// alu_req_sched_if
// Bundles the request and response handshakes of the shared ALU scheduler.
//   req_valid[NREQ]        per-requester request valid          (master -> slave)
//   req_ready[NREQ]        per-requester accept, one-hot/zero   (slave -> master)
//   req_op[4*NREQ]         opcode, requester i at [4i+3:4i]     (master -> slave)
//   req_a/req_b[WIDTH*NREQ] operands, requester i at [WIDTH*i +: WIDTH]
//   rsp_valid / rsp_ready  result handshake
//   rsp_id[IDW]            index of the requester owning the result
//   rsp_data[2*WIDTH]      result
//   rsp_err                divide by zero or illegal opcode
// ---------------------------------------------------------------------------
interface alu_req_sched_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int IDW   = 3
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_req_sched.sv
// ---------------------------------------------------------------------------
// alu_req_sched
// Shares one unsigned ALU between NREQ requesters with round-robin arbitration.
// Single-cycle ops answer one cycle after accept; DIV runs a restoring divider
// for WIDTH cycles. One operation in flight at a time.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_req_sched_if.slave: request handshakes in, tagged result out
// ---------------------------------------------------------------------------
module alu_req_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int IDW   = 3
) (
  input  logic           clk,
  input  logic           rst,
  alu_req_sched_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_DIV = 4'd3;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RESP} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [DW-1:0]    r_rsp_data;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_div_q;
  logic [WIDTH-1:0] r_div_rem;
  logic [WIDTH-1:0] r_div_b;
  logic [CW-1:0]    r_div_cnt;

  // Per-requester views of the packed request fields.
  logic [3:0]       w_op [NREQ];
  logic [WIDTH-1:0] w_a  [NREQ];
  logic [WIDTH-1:0] w_b  [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op[gi] = bus.req_op[4*gi +: 4];
      assign w_a[gi]  = bus.req_a[WIDTH*gi +: WIDTH];
      assign w_b[gi]  = bus.req_b[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... so the last winner is
  // considered last. The inner loop keeps every index a constant.
  logic [NREQ-1:0] w_grant;
  logic            w_found;
  logic [IDW-1:0]  w_grant_idx;

  always_comb begin
    w_grant     = '0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && bus.req_valid[i] &&
            (i == ((int'(r_rr_ptr) + k) % NREQ))) begin
          w_found     = 1'b1;
          w_grant[i]  = 1'b1;
          w_grant_idx = IDW'(i);
        end
      end
    end
  end

  // One-hot mux of the granted requester's fields.
  logic [3:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op = w_op[i];
        w_sel_a  = w_a[i];
        w_sel_b  = w_b[i];
      end
    end
  end

  // Single-cycle datapath. DIV is produced by the iterative divider instead.
  logic [DW-1:0] w_alu_res;
  logic          w_alu_err;

  always_comb begin
    w_alu_res = '0;
    w_alu_err = 1'b0;
    case (w_sel_op)
      4'd0:  w_alu_res = DW'(w_sel_a) + DW'(w_sel_b);
      4'd1:  w_alu_res = DW'(w_sel_a) - DW'(w_sel_b);
      4'd2:  w_alu_res = DW'(w_sel_a) * DW'(w_sel_b);
      4'd3:  w_alu_res = '0;
      4'd4:  w_alu_res = DW'(w_sel_a & w_sel_b);
      4'd5:  w_alu_res = DW'(w_sel_a | w_sel_b);
      4'd6:  w_alu_res = DW'(w_sel_a ^ w_sel_b);
      4'd7:  w_alu_res = DW'((w_sel_a != '0) && (w_sel_b != '0));
      4'd8:  w_alu_res = DW'((w_sel_a != '0) || (w_sel_b != '0));
      4'd9:  w_alu_res = DW'(w_sel_a == w_sel_b);
      4'd10: w_alu_res = DW'(w_sel_a != w_sel_b);
      4'd11: w_alu_res = DW'(w_sel_a <  w_sel_b);
      4'd12: w_alu_res = DW'(w_sel_a <= w_sel_b);
      4'd13: w_alu_res = DW'(w_sel_a >= w_sel_b);
      4'd14: w_alu_res = DW'(w_sel_a >  w_sel_b);
      default: w_alu_err = 1'b1;
    endcase
  end

  // Restoring divider step: the dividend shifts out of r_div_q MSB-first while
  // quotient bits shift in at the bottom. With b=0 every trial subtract
  // succeeds, so the quotient naturally ends as all ones.
  logic [WIDTH:0]   w_rem_shift;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_rem_shift = {r_div_rem, r_div_q[WIDTH-1]};
  assign w_rem_ge    = (w_rem_shift >= {1'b0, r_div_b});
  assign w_rem_next  = w_rem_ge ? WIDTH'(w_rem_shift - {1'b0, r_div_b})
                                : w_rem_shift[WIDTH-1:0];
  assign w_quo_next  = {r_div_q[WIDTH-2:0], w_rem_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= IDW'(NREQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_div_q     <= '0;
      r_div_rem   <= '0;
      r_div_b     <= '0;
      r_div_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_rr_ptr <= w_grant_idx;
            r_rsp_id <= w_grant_idx;
            if (w_sel_op == OP_DIV) begin
              r_div_q   <= w_sel_a;
              r_div_b   <= w_sel_b;
              r_div_rem <= '0;
              r_div_cnt <= '0;
              r_state   <= S_DIV;
            end else begin
              r_rsp_data  <= w_alu_res;
              r_rsp_err   <= w_alu_err;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_DIV: begin
          r_div_q   <= w_quo_next;
          r_div_rem <= w_rem_next;
          r_div_cnt <= r_div_cnt + CW'(1);
          // Final iteration writes the result straight to the response.
          if (r_div_cnt == CW'(WIDTH - 1)) begin
            r_rsp_data  <= DW'(w_quo_next);
            r_rsp_err   <= (r_div_b == '0);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE) ? w_grant : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_alu_req_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_req_sched
// Scoreboard bench for alu_req_sched (WIDTH=4, NREQ=2). An acceptance tracker
// predicts grants from a round-robin model and queues expected responses; a
// separate monitor pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_alu_req_sched;
  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int IDW   = 3;
  localparam int DW    = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_req_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus();

  alu_req_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int id;
    int data;
    bit err;
    int first;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = -1;
  int   last_hs = -1;
  int   m_ptr = NREQ - 1;
  int   last_rsp_data = 0;
  int   last_rsp_id = 0;
  bit   last_rsp_err = 1'b0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference ALU from the opcode table, in plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b,
                                output int d, output bit e);
    int m;
    m = 1 << DW;
    e = 1'b0;
    d = 0;
    case (op)
      0:  d = a + b;
      1:  d = (a - b + m) % m;
      2:  d = a * b;
      3:  if (b == 0) begin d = (1 << WIDTH) - 1; e = 1'b1; end else d = a / b;
      4:  d = a & b;
      5:  d = a | b;
      6:  d = a ^ b;
      7:  d = (a != 0 && b != 0) ? 1 : 0;
      8:  d = (a != 0 || b != 0) ? 1 : 0;
      9:  d = (a == b) ? 1 : 0;
      10: d = (a != b) ? 1 : 0;
      11: d = (a < b) ? 1 : 0;
      12: d = (a <= b) ? 1 : 0;
      13: d = (a >= b) ? 1 : 0;
      14: d = (a > b) ? 1 : 0;
      default: begin d = 0; e = 1'b1; end
    endcase
  endfunction

  // Acceptance tracker: predicts req_ready and queues expected responses.
  int pick, idx, t_op, t_a, t_b, t_d;
  bit t_e, busy;
  logic [NREQ-1:0]       exp_rdy;
  logic [4*NREQ-1:0]     sh_op;
  logic [WIDTH*NREQ-1:0] sh_a, sh_b;

  always @(negedge clk) begin
    if (rst) begin
      m_ptr = NREQ - 1;
      last_acc = -1;
    end else begin
      busy = (last_acc >= 0) && !(last_hs > last_acc && cyc > last_hs);
      pick = -1;
      if (!busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (pick < 0 && ((bus.req_valid >> idx) & 1) != 0) pick = idx;
        end
      end
      exp_rdy = '0;
      if (pick >= 0) exp_rdy = NREQ'(1) << pick;
      chk("req_ready", bus.req_ready, exp_rdy);
      if ((bus.req_valid & bus.req_ready) != 0 && pick >= 0) begin
        sh_op = bus.req_op >> (4 * pick);
        sh_a  = bus.req_a >> (WIDTH * pick);
        sh_b  = bus.req_b >> (WIDTH * pick);
        t_op = int'(sh_op[3:0]);
        t_a  = int'(sh_a[WIDTH-1:0]);
        t_b  = int'(sh_b[WIDTH-1:0]);
        model(t_op, t_a, t_b, t_d, t_e);
        sb.push_back('{pick, t_d, t_e, cyc + 1 + ((t_op == 3) ? WIDTH : 0)});
        m_ptr = pick;
        last_acc = cyc;
      end
    end
  end

  // Response monitor: latency, backpressure stability, scoreboard compare.
  exp_t ent;
  bit   hold = 1'b0;
  bit   prev_v = 1'b0;
  logic [IDW+DW+1:0] snap;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (hold) chk("hold_stable", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err}, snap);
      if (bus.rsp_valid && !prev_v) begin
        if (sb.size() > 0) chk("rsp_latency", cyc, sb[0].first);
        else chk("unexpected_rsp", bus.rsp_valid, 0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_hs", bus.rsp_valid, 0);
        end else begin
          ent = sb.pop_front();
          chk("rsp_id", bus.rsp_id, ent.id);
          chk("rsp_data", bus.rsp_data, ent.data);
          chk("rsp_err", bus.rsp_err, ent.err);
          $display("rsp id=%0d data=%0h err=%0b cycle=%0d", bus.rsp_id, bus.rsp_data, bus.rsp_err, cyc);
        end
        last_hs = cyc;
        last_rsp_data = int'(bus.rsp_data);
        last_rsp_id = int'(bus.rsp_id);
        last_rsp_err = bus.rsp_err;
      end
      hold = bus.rsp_valid && !bus.rsp_ready;
      snap = {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err};
      prev_v = bus.rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_req(input int r, input int op, input int a, input int b);
    bus.req_op[4*r +: 4] = 4'(op);
    bus.req_a[WIDTH*r +: WIDTH] = WIDTH'(a);
    bus.req_b[WIDTH*r +: WIDTH] = WIDTH'(b);
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic issue(input int r, input int op, input int a, input int b);
    tick();
    set_req(r, op, a, b);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin
        tick();
        bus.req_valid[r] = 1'b0;
        return;
      end
      tick();
    end
    chk("accept_timeout", bus.req_ready[r], 1);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.rsp_valid) return;
      tick();
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  int d_op [8] = '{0, 1, 2, 3, 3, 15, 11, 7};
  int d_a  [8] = '{9, 3, 15, 13, 7, 0, 2, 4};
  int d_b  [8] = '{8, 5, 15, 3, 0, 0, 9, 0};
  int d_res[8] = '{8'h11, 8'hFE, 8'hE1, 8'h04, 8'h0F, 8'h00, 8'h01, 8'h00};
  int d_er [8] = '{0, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    int prev_id, n_acc, id;
    logic [NREQ-1:0] acc;
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    rst = 1'b0;

    // Directed vectors, requester 0.
    for (int i = 0; i < 8; i++) begin
      issue(0, d_op[i], d_a[i], d_b[i]);
      wait_idle();
      chk("directed_data", last_rsp_data, d_res[i]);
      chk("directed_err", last_rsp_err, d_er[i]);
    end

    // Logic/compare sweep with random requester and random backpressure.
    rand_rdy = 1'b1;
    for (int op = 4; op <= 14; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          issue($urandom_range(0, NREQ - 1), op, a, b);
    wait_idle();

    // Random ops including arithmetic, divide and illegal.
    for (int n = 0; n < 500; n++)
      issue($urandom_range(0, NREQ - 1), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15));
    wait_idle();
    rand_rdy = 1'b0;
    tick();
    bus.rsp_ready = 1'b1;

    // Round robin: both held valid, refreshed on each accept.
    set_req(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    set_req(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    n_acc = 0;
    prev_id = -1;
    for (int n = 0; n < 400 && n_acc < 8; n++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      tick();
      if (acc != 0) begin
        id = acc[1] ? 1 : 0;
        if (prev_id >= 0) chk("rr_alternate", id, 1 - prev_id);
        prev_id = id;
        n_acc++;
        set_req(id, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end
    end
    chk("rr_count", n_acc, 8);
    bus.req_valid = '0;
    wait_idle();

    // Only requester 1 requesting.
    for (int n = 0; n < 4; n++) begin
      issue(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      wait_idle();
      chk("solo_rsp_id", last_rsp_id, 1);
    end

    // Backpressure: response held 6 cycles while requester 1 waits.
    tick();
    bus.rsp_ready = 1'b0;
    issue(0, 0, 5, 6);
    set_req(1, 5, 3, 6);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.req_ready[1]) break;
      tick();
    end
    tick();
    bus.req_valid = '0;
    chk("bp_resume", last_acc - last_hs, 1);
    chk("bp_data", last_rsp_data, 8'h0B);
    wait_idle();

    // Reset two cycles into a divide.
    issue(0, 3, 13, 3);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_id", bus.rsp_id, 0);
    chk("arst_rsp_data", bus.rsp_data, 0);
    chk("arst_rsp_err", bus.rsp_err, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", bus.rsp_valid, 0);
      tick();
    end
    set_req(0, 0, 1, 1);
    set_req(1, 0, 1, 1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready != 0) begin
        chk("post_rst_grant", bus.req_ready, 2'b01);
        break;
      end
      tick();
    end
    tick();
    bus.req_valid = '0;
    wait_idle();
    chk("post_rst_data", last_rsp_data, 2);
    chk("post_rst_id", last_rsp_id, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog timeout");
  end
endmodule

// File: doc/alu_req_sched.md
Name: alu_req_sched

Overview:
- Shares one unsigned ALU between NREQ requesters using round-robin arbitration.
- Supported ops: logical, bitwise, arithmetic and compare.
- Every op completes in one cycle except divide, which runs on an iterative restoring divider that takes WIDTH cycles.
- Sits between client blocks and the shared datapath. One operation is in flight at a time, and its result is returned with the requester index.

Parameters:
- WIDTH, 4, operand width in bits (≥2).
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of rsp_id (must satisfy 2^IDW ≥ NREQ).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept, one-hot or zero.
- req_op  input  4*NREQ  opcode; requester i uses bits [4i+3:4i].
- req_a  input  WIDTH*NREQ  operand A; requester i uses bits [WIDTH*i +: WIDTH].
- req_b  input  WIDTH*NREQ  operand B; same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_data  output  2*WIDTH  result, zero-extended unless stated otherwise.
- rsp_err  output  1  divide by zero or illegal opcode.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=NREQ-1.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, req_ready=0.
  - Divider registers cleared.
  - Reset asserted mid-divide aborts the op. No response is ever produced for it.
- FSM states: IDLE, DIV, RESP.
  - IDLE: req_ready is combinational, = grant when state==IDLE, else 0.
    - grant = first i with req_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
    - On handshake (req_valid[i] & req_ready[i]): latch op, a, b and id; set rr_ptr=i.
    - If op is DIV → DIV. Otherwise compute the result and go to RESP.
  - DIV: one restoring-division iteration per cycle, exactly WIDTH cycles, then RESP.
  - RESP: rsp_valid=1, with rsp_id, rsp_data and rsp_err held stable.
    - On rsp_ready=1 → IDLE, and rsp_valid drops the next cycle.
    - No request is accepted in RESP or DIV.
- Latency from an accept at edge t:
  - Non-divide: rsp_valid high from t+1.
  - Divide: rsp_valid high from t+1+WIDTH.
  - Minimum issue interval is 2 cycles (accept, respond-with-ready, then IDLE).
- Opcodes (unsigned arithmetic):
  - 0 ADD: a+b, WIDTH+1 bits.
  - 1 SUB: (a-b) mod 2^(2*WIDTH).
  - 2 MUL: full 2*WIDTH-bit product.
  - 3 DIV: quotient a/b.
  - 4 AND, 5 OR, 6 XOR: WIDTH bits.
  - 7 LAND: (a≠0)&&(b≠0). 8 LOR: (a≠0)||(b≠0).
  - 9 EQ, 10 NE, 11 LT, 12 LE, 13 GE, 14 GT: 1-bit results.
  - 15: illegal → rsp_data=0, rsp_err=1.
- Divide by zero: still takes WIDTH cycles; quotient = all ones in the low WIDTH bits; rsp_err=1.
- Request rules:
  - A requester must hold req_valid and its fields stable until accepted.
  - Dropping req_valid before accept is permitted; that request is simply not granted.
- Simultaneous requests:
  - Exactly one grant per accept.
  - rr_ptr rotation guarantees a waiting requester is served within NREQ accepts.
- Response backpressure: rsp_ready may stay low indefinitely; outputs hold with no corruption.

Test Plan:
- ADD/SUB/MUL/DIV (WIDTH=4), requester 0 only:
  - ADD a=9, b=8 → rsp_data=8'h11, err=0, rsp_valid one cycle after accept.
  - SUB a=3, b=5 → 8'hFE.
  - MUL a=15, b=15 → 8'hE1.
  - DIV a=13, b=3 → 8'h04, rsp_valid exactly 5 cycles after accept.
- Divide by zero and illegal opcode:
  - DIV a=7, b=0 → rsp_data=8'h0F, rsp_err=1 after 5 cycles.
  - op=15 → rsp_data=0, rsp_err=1.
- Compare/logic sweep: all 16×16 operand pairs for ops 4..14 vs a reference model. Example: LT a=2, b=9 → 8'h01; LAND a=4, b=0 → 8'h00.
- Round-robin, NREQ=2:
  - Both req_valid held high, rsp_ready=1 → accept ids alternate 0,1,0,1 for 8 ops; rsp_id matches each.
  - Only requester 1 valid → it is granted every opportunity.
- Backpressure: rsp_ready=0 for 6 cycles during RESP → rsp_valid/rsp_data/rsp_id stable, req_ready=0 throughout; accept resumes 1 cycle after rsp_ready=1.
- Reset mid-divide: assert rst 2 cycles into DIV a=13, b=3 → all outputs 0 immediately; after release no response appears; a new ADD a=1, b=1 returns 8'h02 with rsp_id correct and grant starting from requester 0.
